// File: rtl/fb_arbiter.sv
// fb_arbiter: shares the single-port 1-bpp frame-buffer RAM between the TFT
// display reader (highest priority), an internal screen-clear engine and the
// waveform plot writer.
// Optional build macro FB_WR_FIFO_EN: put a 4-entry {addr,data} FIFO in front
// of the plot write port. The range check is then applied at dequeue time.
module fb_arbiter #(
    parameter int H_RES  = 800,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              tft_req,
    input  logic [ADDR_W-1:0] tft_addr,
    output logic              tft_data,
    output logic              tft_vld,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic              ram_wdata,
    input  logic              ram_rdata
);

    localparam logic [ADDR_W-1:0] FB_PIXELS = ADDR_W'(H_RES * V_RES);
    localparam logic [ADDR_W-1:0] CLR_LAST  = FB_PIXELS - ADDR_W'(1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic              r_tft_data, r_tft_vld;

    // A plot-write slot exists only when neither the display nor the clear
    // engine wants the RAM. clr_start also closes the slot so a clear always
    // beats a concurrent write. Reset closes it so nothing is accepted then.
    logic              w_slot;
    logic              w_pw_vld;
    logic [ADDR_W-1:0] w_pw_addr;
    logic              w_pw_data;
    logic              w_pw_oor;
    logic              w_pw_wr;

    assign w_slot = ~rst & (r_state == S_IDLE) & ~tft_req & ~clr_start;

`ifdef FB_WR_FIFO_EN
    logic [ADDR_W-1:0] r_fifo_addr [4];
    logic [3:0]        r_fifo_data;
    logic [1:0]        r_wp, r_rp;
    logic [2:0]        r_cnt;
    logic              w_push, w_pop, w_full, w_empty;

    assign w_full    = (r_cnt == 3'd4);
    assign w_empty   = (r_cnt == 3'd0);
    assign wr_ready  = ~rst & ~w_full;
    // A push landing together with clr_start is flushed along with the rest.
    assign w_push    = wr_valid & wr_ready & ~clr_start;
    assign w_pop     = w_slot & ~w_empty;
    assign w_pw_vld  = w_pop;
    assign w_pw_addr = r_fifo_addr[r_rp];
    assign w_pw_data = r_fifo_data[r_rp];

    // FIFO pointers/storage; clr_start discards everything queued.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_fifo_data <= '0;
            for (int i = 0; i < 4; i++) r_fifo_addr[i] <= '0;
        end else if (clr_start) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wp] <= wr_addr;
                r_fifo_data[r_wp] <= wr_data;
                r_wp <= r_wp + 2'd1;
            end
            if (w_pop) r_rp <= r_rp + 2'd1;
            r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
        end
    end
`else
    assign wr_ready  = w_slot;
    assign w_pw_vld  = wr_valid & w_slot;
    assign w_pw_addr = wr_addr;
    assign w_pw_data = wr_data;
`endif

    assign w_pw_oor = (w_pw_addr >= FB_PIXELS);
    assign w_pw_wr  = w_pw_vld & ~w_pw_oor;
    assign wr_drop  = w_pw_vld & w_pw_oor;
    assign clr_busy = (r_state == S_CLEAR);
    assign tft_data = r_tft_data;
    assign tft_vld  = r_tft_vld;

    // FSM state and clear-address counter.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next state: the counter only advances when the clear write was really
    // issued, i.e. on cycles the display left free.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (clr_start) begin
                    w_clr_cnt_nxt = '0;
                end else if (!tft_req) begin
                    if (r_clr_cnt == CLR_LAST) w_state_nxt = S_IDLE;
                    else w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM port mux: display read, then clear write, then plot write.
    always_comb begin
        ram_addr  = '0;
        ram_rden  = 1'b0;
        ram_wren  = 1'b0;
        ram_wdata = 1'b0;
        if (tft_req) begin
            ram_addr = tft_addr;
            ram_rden = 1'b1;
        end else if (r_state == S_CLEAR) begin
            ram_addr = r_clr_cnt;
            ram_wren = 1'b1;
        end else if (w_pw_wr) begin
            ram_addr  = w_pw_addr;
            ram_wren  = 1'b1;
            ram_wdata = w_pw_data;
        end
    end

    // Read return: track rden through the RAM latency, then register the bit.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_tft_vld  <= 1'b0;
            r_tft_data <= 1'b0;
        end else begin
            r_vld_pipe[0] <= ram_rden;
            for (int i = 1; i < RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_tft_vld <= r_vld_pipe[RD_LAT-1];
            if (r_vld_pipe[RD_LAT-1]) r_tft_data <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter (default build). A reduced 40x32 frame keeps
// the full clear sweep short; the RAM is a behavioural 1-cycle model.
module tb_fb_arbiter;

    localparam int H_RES  = 40;
    localparam int V_RES  = 32;
    localparam int ADDR_W = 19;
    localparam int FB     = H_RES * V_RES;   // 1280

    logic              clk_vga = 1'b0;
    logic              rst;
    logic              tft_req;
    logic [ADDR_W-1:0] tft_addr;
    logic              tft_data, tft_vld;
    logic              clr_start, clr_busy;
    logic              wr_valid, wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data, wr_drop;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rden, ram_wren, ram_wdata;
    logic              ram_rdata;

    int checks = 0;
    int errors = 0;

    logic mem [0:4095];
    logic tb_fill = 1'b0;
    logic tb_fill_val = 1'b0;

    always #5 clk_vga = ~clk_vga;

    fb_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .RD_LAT(1)) dut (
        .clk_vga(clk_vga), .rst(rst),
        .tft_req(tft_req), .tft_addr(tft_addr), .tft_data(tft_data), .tft_vld(tft_vld),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM, read latency 1, plus a bulk-fill backdoor.
    always @(posedge clk_vga) begin
        if (tb_fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= tb_fill_val;
        end else begin
            if (ram_wren) mem[ram_addr[11:0]] <= ram_wdata;
            if (ram_rden) ram_rdata <= mem[ram_addr[11:0]];
        end
    end

    task automatic fill(input logic v);
        @(negedge clk_vga);
        tb_fill = 1'b1;
        tb_fill_val = v;
        @(negedge clk_vga);
        tb_fill = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; tft_req = 0; tft_addr = '0; clr_start = 0;
        wr_valid = 0; wr_addr = '0; wr_data = 0; ram_rdata = 0;
        #1;
        checks++;
        if ({tft_data, tft_vld, clr_busy, wr_ready, wr_drop, ram_rden, ram_wren, ram_wdata} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000",
                {tft_data, tft_vld, clr_busy, wr_ready, wr_drop, ram_rden, ram_wren, ram_wdata});
        end
        checks++;
        if (ram_addr !== '0) begin
            errors++; $display("FAIL reset_addr got %0d want 0", ram_addr);
        end
        @(negedge clk_vga);
        @(negedge clk_vga);
        rst = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || tft_vld !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b rdy=%b vld=%b want 0 1 0", clr_busy, wr_ready, tft_vld);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic exp, input string nm);
        @(negedge clk_vga);
        tft_req = 1'b1; tft_addr = a;
        #1;
        checks++;
        if (ram_rden !== 1'b1 || ram_wren !== 1'b0 || ram_addr !== a || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_issue got rden=%b wren=%b addr=%0d rdy=%b want 1 0 %0d 0",
                nm, ram_rden, ram_wren, ram_addr, wr_ready, a);
        end
        @(negedge clk_vga);
        tft_req = 1'b0;
        #1;
        checks++;
        if (tft_vld !== 1'b0) begin
            errors++; $display("FAIL %s_early_vld got %b want 0", nm, tft_vld);
        end
        @(negedge clk_vga);
        #1;
        checks++;
        if (tft_vld !== 1'b1 || tft_data !== exp) begin
            errors++;
            $display("FAIL %s_return got vld=%b data=%b want 1 %b", nm, tft_vld, tft_data, exp);
        end
        @(negedge clk_vga);
        #1;
        checks++;
        if (tft_vld !== 1'b0 || tft_data !== exp) begin
            errors++;
            $display("FAIL %s_hold got vld=%b data=%b want 0 %b", nm, tft_vld, tft_data, exp);
        end
    endtask

    task automatic test_read;
        fill(1'b1);
        do_read(19'd1234, 1'b1, "read_one");
        fill(1'b0);
        do_read(19'd1234, 1'b0, "read_zero");
    endtask

    task automatic test_write;
        @(negedge clk_vga);
        wr_valid = 1'b1; wr_addr = 19'd801; wr_data = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 19'd801 || ram_wdata !== 1'b1 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL write_801 got rdy=%b wren=%b addr=%0d wd=%b drop=%b want 1 1 801 1 0",
                wr_ready, ram_wren, ram_addr, ram_wdata, wr_drop);
        end
        @(negedge clk_vga);
        wr_valid = 1'b0;
        #1;
        checks++;
        if (mem[801] !== 1'b1 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL write_801_mem got mem=%b wren=%b want 1 0", mem[801], ram_wren);
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        @(negedge clk_vga);
        tft_req = 1'b1; tft_addr = 19'd5;
        wr_valid = 1'b1; wr_addr = 19'd900; wr_data = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (wr_ready !== 1'b0 || ram_wren !== 1'b0 || ram_rden !== 1'b1 || ram_addr !== 19'd5) bad++;
            @(negedge clk_vga);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_cycles got %0d bad cycles want 0", bad);
        end
        tft_req = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 19'd900 || ram_wdata !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got rdy=%b wren=%b addr=%0d wd=%b want 1 1 900 1",
                wr_ready, ram_wren, ram_addr, ram_wdata);
        end
        @(negedge clk_vga);
        wr_valid = 1'b0;
        #1;
        checks++;
        if (mem[900] !== 1'b1) begin
            errors++; $display("FAIL stall_mem got %b want 1", mem[900]);
        end
    endtask

    task automatic test_drop;
        @(negedge clk_vga);
        wr_valid = 1'b1; wr_addr = 19'(FB); wr_data = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || ram_wren !== 1'b0 || wr_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_first got rdy=%b wren=%b drop=%b want 1 0 1", wr_ready, ram_wren, wr_drop);
        end
        @(negedge clk_vga);
        wr_valid = 1'b0;
        #1;
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++; $display("FAIL drop_pulse got %b want 0", wr_drop);
        end
        @(negedge clk_vga);
        wr_valid = 1'b1; wr_addr = 19'(FB - 1); wr_data = 1'b1;
        #1;
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== 19'(FB - 1) || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_last_in_range got wren=%b addr=%0d drop=%b want 1 %0d 0",
                ram_wren, ram_addr, wr_drop, FB - 1);
        end
        @(negedge clk_vga);
        wr_addr = 19'h7FFFF;
        #1;
        checks++;
        if (ram_wren !== 1'b0 || wr_drop !== 1'b1) begin
            errors++; $display("FAIL drop_max got wren=%b drop=%b want 0 1", ram_wren, wr_drop);
        end
        @(negedge clk_vga);
        wr_valid = 1'b0;
    endtask

    task automatic test_clear;
        int exp_addr = 0;
        int order_bad = 0;
        int overlap = 0;
        int busy_bad = 0;
        int cyc = 0;
        fill(1'b1);
        @(negedge clk_vga);
        clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 19'd10; wr_data = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL clear_beats_write got rdy=%b wren=%b want 0 0", wr_ready, ram_wren);
        end
        while (exp_addr < FB && cyc < 4 * FB) begin
            @(negedge clk_vga);
            clr_start = 1'b0; wr_valid = 1'b0;
            tft_req = cyc[0]; tft_addr = 19'd7;
            #1;
            if (clr_busy !== 1'b1) busy_bad++;
            if (ram_rden && ram_wren) overlap++;
            if (ram_wren) begin
                if (ram_addr !== 19'(exp_addr) || ram_wdata !== 1'b0) order_bad++;
                exp_addr++;
            end
            cyc++;
        end
        @(negedge clk_vga);
        tft_req = 1'b0;
        #1;
        checks++;
        if (exp_addr != FB) begin
            errors++; $display("FAIL clear_count got %0d want %0d", exp_addr, FB);
        end
        checks++;
        if (order_bad != 0 || overlap != 0 || busy_bad != 0) begin
            errors++;
            $display("FAIL clear_sequence got order_bad=%0d overlap=%0d busy_bad=%0d want 0 0 0",
                order_bad, overlap, busy_bad);
        end
        checks++;
        if (clr_busy !== 1'b0 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL clear_done got busy=%b wren=%b want 0 0", clr_busy, ram_wren);
        end
        checks++;
        if (mem[0] !== 1'b0 || mem[640] !== 1'b0 || mem[FB-1] !== 1'b0 || mem[FB] !== 1'b1) begin
            errors++;
            $display("FAIL clear_mem got %b%b%b%b want 0001", mem[0], mem[640], mem[FB-1], mem[FB]);
        end
    endtask

    task automatic test_reset_mid_clear;
        int cyc = 0;
        bit hit = 0;
        fill(1'b1);
        @(negedge clk_vga);
        clr_start = 1'b1;
        @(negedge clk_vga);
        clr_start = 1'b0;
        while (!hit && cyc < 2 * FB) begin
            #1;
            if (ram_wren && ram_addr == 19'd1000) hit = 1;
            else @(negedge clk_vga);
            cyc++;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL midclr_reach got timeout want addr 1000");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL midclr_abort got busy=%b wren=%b want 0 0", clr_busy, ram_wren);
        end
        @(negedge clk_vga);
        rst = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL midclr_idle got busy=%b rdy=%b wren=%b want 0 1 0", clr_busy, wr_ready, ram_wren);
        end
        @(negedge clk_vga);
        #1;
        checks++;
        if (mem[999] !== 1'b0 || mem[1000] !== 1'b1 || mem[1001] !== 1'b1 || ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL midclr_mem got %b%b%b wren=%b want 011 0", mem[999], mem[1000], mem[1001], ram_wren);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_stall();
        test_drop();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
